// File: rtl/cdb_writeback_unit_pkg.sv
// Shared types and constants for the CDB writeback unit.
// Holds the CDB field layout, the producer tag type and the
// destination one-hot validity helper.
package cdb_writeback_unit_pkg;
  localparam int DATA_W   = 10;
  localparam int TAG_W    = 3;
  localparam int NUM_REGS = 3;
  localparam int CDB_W    = 16;
  // CDB field offsets
  localparam int DEST_MSB = 15;
  localparam int DEST_LSB = 13;
  localparam int POS_MSB  = 12;
  localparam int POS_LSB  = 11;
  localparam int UNIT_BIT = 10;
  localparam int DATA_MSB = 9;

  typedef logic [TAG_W-1:0] tag_t;

  // Bit 0 of dest selects R0; packed order matches the bus layout MSB-first.
  typedef struct packed {
    logic [NUM_REGS-1:0] dest;
    logic [1:0]          pos;
    logic                unit;
    logic [DATA_W-1:0]   data;
  } cdb_t;

  function automatic logic dest_onehot(input logic [NUM_REGS-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction
endpackage

// File: rtl/cdb_writeback_unit_fifo.sv
// Small capture buffer for CDB broadcasts.
// Ports: clk_i/rst_ni (async low), push_i/data_i write side,
// pop_i/data_o read side (data_o shows the head), full_o/empty_o status.
// Push on full and pop on empty are ignored. DEPTH must be a power of two.
module cdb_writeback_unit_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [PW-1:0]               wr_q, rd_q;
  logic [PW:0]                 cnt_q;
  logic                        do_push, do_pop;

  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rd_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
    end
  end
endmodule

// File: rtl/cdb_writeback_unit.sv
// CDB receive side: buffers arbiter broadcasts, commits one per cycle to the
// register file, tracks per-register pending producer tags and re-broadcasts
// each well-formed result as a registered writeback pulse.
// Ports: clk_i/rst_ni (async low); cdb_valid_i/cdb_i/cdb_ready_o broadcast
// input; issue_valid_i/issue_reg_i/issue_tag_i rename; reg_data_o/reg_busy_o/
// reg_tag_o register status (R0 in LSBs); wb_valid_o/wb_tag_o/wb_data_o
// writeback pulse; discard_cnt_o saturating count of suppressed writes.
module cdb_writeback_unit
  import cdb_writeback_unit_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       cdb_valid_i,
  input  logic [CDB_W-1:0]           cdb_i,
  output logic                       cdb_ready_o,
  input  logic                       issue_valid_i,
  input  logic [1:0]                 issue_reg_i,
  input  logic [TAG_W-1:0]           issue_tag_i,
  output logic [NUM_REGS*DATA_W-1:0] reg_data_o,
  output logic [NUM_REGS-1:0]        reg_busy_o,
  output logic [NUM_REGS*TAG_W-1:0]  reg_tag_o,
  output logic                       wb_valid_o,
  output logic [TAG_W-1:0]           wb_tag_o,
  output logic [DATA_W-1:0]          wb_data_o,
  output logic [7:0]                 discard_cnt_o
);
  logic                              fifo_full, fifo_empty, pop;
  logic [CDB_W-1:0]                  head_raw;
  cdb_t                              head;
  tag_t                              ctag;
  logic                              well_formed, suppress;
  logic [NUM_REGS-1:0]               hit, iss;

  logic [NUM_REGS-1:0][DATA_W-1:0]   data_q;
  logic [NUM_REGS-1:0]               busy_q;
  tag_t [NUM_REGS-1:0]               tag_q;
  logic                              wb_valid_q;
  tag_t                              wb_tag_q;
  logic [DATA_W-1:0]                 wb_data_q;
  logic [7:0]                        discard_q;

  // Ready only looks at fullness, so it never depends on the same-cycle pop.
  assign cdb_ready_o = !fifo_full;
  assign pop         = !fifo_empty;

  cdb_writeback_unit_fifo #(.WIDTH(CDB_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (cdb_valid_i),
    .data_i  (cdb_i),
    .pop_i   (pop),
    .data_o  (head_raw),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head        = cdb_t'(head_raw);
  assign ctag        = {head.unit, head.pos};
  assign well_formed = pop && dest_onehot(head.dest);

  always_comb begin
    hit = '0;
    iss = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      hit[i] = well_formed && head.dest[i] && busy_q[i] && (tag_q[i] == ctag);
      // Out-of-range issue_reg matches no index and is dropped here.
      iss[i] = issue_valid_i && (issue_reg_i == 2'(i));
    end
  end

  // Any popped entry that writes no register counts: malformed or stale.
  assign suppress = pop && (hit == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q     <= '0;
      busy_q     <= '0;
      tag_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_tag_q   <= '0;
      wb_data_q  <= '0;
      discard_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (hit[i]) begin
          data_q[i] <= head.data;
          busy_q[i] <= 1'b0;
        end
        // Issue comes last so a rename in the commit cycle keeps the register busy.
        if (iss[i]) begin
          busy_q[i] <= 1'b1;
          tag_q[i]  <= issue_tag_i;
        end
      end
      wb_valid_q <= well_formed;
      if (well_formed) begin
        wb_tag_q  <= ctag;
        wb_data_q <= head.data;
      end
      if (suppress && discard_q != 8'hFF) discard_q <= discard_q + 8'd1;
    end
  end

  assign reg_data_o    = data_q;
  assign reg_busy_o    = busy_q;
  assign reg_tag_o     = tag_q;
  assign wb_valid_o    = wb_valid_q;
  assign wb_tag_o      = wb_tag_q;
  assign wb_data_o     = wb_data_q;
  assign discard_cnt_o = discard_q;
endmodule

// File: tb/tb_cdb_writeback_unit.sv
module tb_cdb_writeback_unit;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cdb_valid = 1'b0;
  logic [15:0] cdb = '0;
  logic        cdb_ready;
  logic        issue_valid = 1'b0;
  logic [1:0]  issue_reg = '0;
  logic [2:0]  issue_tag = '0;
  logic [29:0] reg_data;
  logic [2:0]  reg_busy;
  logic [8:0]  reg_tag;
  logic        wb_valid;
  logic [2:0]  wb_tag;
  logic [9:0]  wb_data;
  logic [7:0]  discard_cnt;

  int n_tests = 0, n_fail = 0;

  cdb_writeback_unit dut (
    .clk_i(clk), .rst_ni(rst_n), .cdb_valid_i(cdb_valid), .cdb_i(cdb), .cdb_ready_o(cdb_ready),
    .issue_valid_i(issue_valid), .issue_reg_i(issue_reg), .issue_tag_i(issue_tag),
    .reg_data_o(reg_data), .reg_busy_o(reg_busy), .reg_tag_o(reg_tag),
    .wb_valid_o(wb_valid), .wb_tag_o(wb_tag), .wb_data_o(wb_data), .discard_cnt_o(discard_cnt));

  always #5 clk = ~clk;

  // Reference model: a queue of captured broadcasts plus a register table.
  logic [15:0] mq[$];
  logic [9:0]  m_data[3];
  logic        m_busy[3];
  logic [2:0]  m_tag[3];
  logic        m_wbv;
  logic [2:0]  m_wbt;
  logic [9:0]  m_wbd;
  int          m_disc;

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < 3; i++) begin m_data[i] = '0; m_busy[i] = 0; m_tag[i] = '0; end
    m_wbv = 0; m_wbt = '0; m_wbd = '0; m_disc = 0;
  endtask

  // One clock edge of the specified behaviour, using the inputs now applied.
  task automatic model_edge();
    bit room = (mq.size() < 2);
    logic [15:0] h;
    int r;
    m_wbv = 0;
    if (mq.size() > 0) begin
      h = mq.pop_front();
      case (h[15:13])
        3'b001: r = 0;
        3'b010: r = 1;
        3'b100: r = 2;
        default: r = -1;
      endcase
      if (r < 0) begin
        if (m_disc < 255) m_disc++;
      end else begin
        m_wbv = 1; m_wbt = {h[10], h[12:11]}; m_wbd = h[9:0];
        if (m_busy[r] && m_tag[r] == m_wbt) begin m_data[r] = h[9:0]; m_busy[r] = 0; end
        else if (m_disc < 255) m_disc++;
      end
    end
    if (issue_valid && issue_reg < 2'd3) begin
      m_busy[issue_reg] = 1; m_tag[issue_reg] = issue_tag;
    end
    if (cdb_valid && room) mq.push_back(cdb);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_all();
    logic [29:0] d;
    logic [2:0]  b;
    logic [8:0]  t;
    for (int i = 0; i < 3; i++) begin
      d[i*10 +: 10] = m_data[i]; b[i] = m_busy[i]; t[i*3 +: 3] = m_tag[i];
    end
    chk("cdb_ready", 64'(cdb_ready), 64'(mq.size() < 2));
    chk("reg_data", 64'(reg_data), 64'(d));
    chk("reg_busy", 64'(reg_busy), 64'(b));
    chk("reg_tag", 64'(reg_tag), 64'(t));
    chk("wb_valid", 64'(wb_valid), 64'(m_wbv));
    if (m_wbv) begin
      chk("wb_tag", 64'(wb_tag), 64'(m_wbt));
      chk("wb_data", 64'(wb_data), 64'(m_wbd));
    end
    chk("discard_cnt", 64'(discard_cnt), 64'(m_disc));
  endtask

  task automatic drive(input logic cv, input logic [15:0] c, input logic iv,
                       input logic [1:0] ir, input logic [2:0] it);
    cdb_valid = cv; cdb = c; issue_valid = iv; issue_reg = ir; issue_tag = it;
  endtask

  // Called at posedge+1; inputs already applied.
  task automatic step();
    @(negedge clk);
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Called at posedge+1. Holds cdb_valid high during reset, as the arbiter might.
  task automatic do_reset();
    drive(1'b1, 16'h4C2A, 1'b0, 2'd0, 3'd0);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst cdb_ready", 64'(cdb_ready), 64'd1);
    chk("rst reg_data", 64'(reg_data), 64'd0);
    chk("rst reg_busy", 64'(reg_busy), 64'd0);
    chk("rst reg_tag", 64'(reg_tag), 64'd0);
    chk("rst wb", 64'({wb_valid, wb_tag, wb_data}), 64'd0);
    chk("rst discard", 64'(discard_cnt), 64'd0);
    rst_n = 1'b1;
    drive(1'b0, 16'h0, 1'b0, 2'd0, 3'd0);
  endtask

  function automatic logic [15:0] mk(input logic [2:0] dest, input logic [2:0] tag, input logic [9:0] d);
    return {dest, tag[1:0], tag[2], d};
  endfunction

  typedef struct {
    logic cv; logic [15:0] c; logic iv; logic [1:0] ir; logic [2:0] it;
    int chk; int r; logic [9:0] d; logic b; logic [2:0] t;
    logic wv; logic [2:0] wt; logic [9:0] wd; logic [7:0] dc;
  } vec_t;
  vec_t vec[13];

  initial begin
    // chk: 0 none, 1 register + wb + discard, 2 wb_valid + discard only
    vec[0]  = '{1'b0, 16'h0000, 1'b1, 2'd1, 3'd5, 0, 0, 10'h0,  1'b0, 3'd0, 1'b0, 3'd0, 10'h0,  8'd0};
    vec[1]  = '{1'b1, 16'h4C2A, 1'b0, 2'd0, 3'd0, 0, 0, 10'h0,  1'b0, 3'd0, 1'b0, 3'd0, 10'h0,  8'd0};
    vec[2]  = '{1'b0, 16'h0000, 1'b0, 2'd0, 3'd0, 1, 1, 10'h2A, 1'b0, 3'd5, 1'b1, 3'd5, 10'h2A, 8'd0};
    vec[3]  = '{1'b0, 16'h0000, 1'b1, 2'd0, 3'd1, 0, 0, 10'h0,  1'b0, 3'd0, 1'b0, 3'd0, 10'h0,  8'd0};
    vec[4]  = '{1'b0, 16'h0000, 1'b1, 2'd0, 3'd2, 0, 0, 10'h0,  1'b0, 3'd0, 1'b0, 3'd0, 10'h0,  8'd0};
    vec[5]  = '{1'b1, 16'h2807, 1'b0, 2'd0, 3'd0, 0, 0, 10'h0,  1'b0, 3'd0, 1'b0, 3'd0, 10'h0,  8'd0};
    vec[6]  = '{1'b0, 16'h0000, 1'b0, 2'd0, 3'd0, 1, 0, 10'h0,  1'b1, 3'd2, 1'b1, 3'd1, 10'h7,  8'd1};
    vec[7]  = '{1'b0, 16'h0000, 1'b1, 2'd2, 3'd0, 0, 0, 10'h0,  1'b0, 3'd0, 1'b0, 3'd0, 10'h0,  8'd0};
    vec[8]  = '{1'b1, 16'h8009, 1'b0, 2'd0, 3'd0, 0, 0, 10'h0,  1'b0, 3'd0, 1'b0, 3'd0, 10'h0,  8'd0};
    vec[9]  = '{1'b0, 16'h0000, 1'b1, 2'd2, 3'd6, 1, 2, 10'h9,  1'b1, 3'd6, 1'b1, 3'd0, 10'h9,  8'd1};
    vec[10] = '{1'b1, 16'h0005, 1'b0, 2'd0, 3'd0, 0, 0, 10'h0,  1'b0, 3'd0, 1'b0, 3'd0, 10'h0,  8'd0};
    vec[11] = '{1'b1, 16'hC005, 1'b0, 2'd0, 3'd0, 2, 0, 10'h0,  1'b0, 3'd0, 1'b0, 3'd0, 10'h0,  8'd2};
    vec[12] = '{1'b0, 16'h0000, 1'b0, 2'd0, 3'd0, 2, 0, 10'h0,  1'b0, 3'd0, 1'b0, 3'd0, 10'h0,  8'd3};

    @(posedge clk); #1;
    do_reset();

    // Directed table: match, stale, collision, malformed.
    for (int k = 0; k < 13; k++) begin
      drive(vec[k].cv, vec[k].c, vec[k].iv, vec[k].ir, vec[k].it);
      step();
      if (vec[k].chk == 1) begin
        chk($sformatf("v%0d data", k), 64'(reg_data[vec[k].r*10 +: 10]), 64'(vec[k].d));
        chk($sformatf("v%0d busy", k), 64'(reg_busy[vec[k].r]), 64'(vec[k].b));
        chk($sformatf("v%0d tag", k), 64'(reg_tag[vec[k].r*3 +: 3]), 64'(vec[k].t));
        chk($sformatf("v%0d wb_tag", k), 64'(wb_tag), 64'(vec[k].wt));
        chk($sformatf("v%0d wb_data", k), 64'(wb_data), 64'(vec[k].wd));
      end
      if (vec[k].chk != 0) begin
        chk($sformatf("v%0d wb_valid", k), 64'(wb_valid), 64'(vec[k].wv));
        chk($sformatf("v%0d discard", k), 64'(discard_cnt), 64'(vec[k].dc));
      end
    end

    // Back-to-back distinct broadcasts held valid: commits in order, none lost.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, mk(3'b100, 3'(k), 10'(10'h100 + k)), 1'b0, 2'd0, 3'd0);
      step();
      if (k > 0) chk($sformatf("b2b wb_data %0d", k), 64'(wb_data), 64'(10'h100 + k - 1));
    end
    drive(1'b0, 16'h0, 1'b0, 2'd0, 3'd0);
    step();
    chk("b2b last", 64'(wb_data), 64'(10'h103));

    // Saturation: stale commits to R0 (pending tag 2, broadcasting tag 1).
    for (int k = 0; k < 260; k++) begin
      drive(1'b1, 16'h2807, 1'b0, 2'd0, 3'd0);
      step();
    end
    drive(1'b0, 16'h0, 1'b0, 2'd0, 3'd0);
    step();
    chk("discard saturated", 64'(discard_cnt), 64'd255);

    // Reset mid-transfer: buffered entry must be flushed.
    drive(1'b1, mk(3'b001, 3'd2, 10'h55), 1'b0, 2'd0, 3'd0);
    step();
    do_reset();
    step();
    chk("flush no wb", 64'(wb_valid), 64'd0);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      logic [2:0] dest, tg;
      int r;
      r = $urandom_range(0, 2);
      dest = ($urandom_range(0, 9) < 8) ? 3'(1 << r) : 3'($urandom_range(0, 7));
      tg = $urandom_range(0, 1) ? m_tag[r] : 3'($urandom_range(0, 7));
      drive(1'($urandom_range(0, 3) != 0), mk(dest, tg, 10'($urandom)),
            1'($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
      step();
      if (k == 200) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
